sprite_queue_fifo: RTL and testbench



---
 rtl/sprite_queue_fifo.sv | 67 ++++++
 tb/tb_sprite_queue_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_queue_fifo.sv
// sprite_queue_fifo: assembles 6-byte sprite records into a FIFO of {id, x, y, scale} entries
module sprite_queue_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enqueue_en,
    input  logic [7:0]  enqueue_data,
    input  logic        dequeue,
    output logic        is_empty,
    output logic [7:0]  sprite_id,
    output logic [15:0] sprite_x,
    output logic [15:0] sprite_y,
    output logic [7:0]  sprite_scale
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    byte_cnt;
    logic [39:0]   stage;
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [47:0]   entry, head;
    logic          complete, pop, push;

    // Bytes shift in from the top, so after five bytes the id sits in the low byte
    assign complete = enqueue_en && byte_cnt == 3'd5;
    assign pop      = dequeue && count != '0;
    assign push     = complete && (!count[AW] || pop);
    assign entry    = {stage[7:0], stage[23:8], stage[39:24], enqueue_data};
    assign is_empty = count == '0;
    assign head     = is_empty ? '0 : mem[rd_ptr];
    assign {sprite_id, sprite_x, sprite_y, sprite_scale} = head;

    // Record assembly: counter and staging shift register; a gap aborts a partial record
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            stage    <= '0;
        end else if (enqueue_en) begin
            byte_cnt <= complete ? 3'd0 : byte_cnt + 3'd1;
            stage    <= complete ? stage : {enqueue_data, stage[39:8]};
        end else begin
            byte_cnt <= '0;
        end
    end

    // Pointers and occupancy; a pop on the same edge frees room for a push into a full queue
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= (push && !pop) ? count + (AW+1)'(1) :
                      (pop && !push) ? count - (AW+1)'(1) : count;
        end
    end

    // Entry storage, needs no reset because outputs are zeroed while empty
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= entry;
    end
endmodule

// File: tb/tb_sprite_queue_fifo.sv
// tb_sprite_queue_fifo: directed vector table plus fill/drain sequences for sprite_queue_fifo
module tb_sprite_queue_fifo;
    localparam int DEPTH = 16;

    logic        clk = 0;
    logic        reset = 1;
    logic        enqueue_en = 0;
    logic [7:0]  enqueue_data = 0;
    logic        dequeue = 0;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [7:0]  data;
        logic        deq;
        logic        e;
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  sc;
    } vec_t;

    vec_t vecs[$];

    sprite_queue_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .enqueue_en(enqueue_en),
        .enqueue_data(enqueue_data),
        .dequeue(dequeue),
        .is_empty(is_empty),
        .sprite_id(sprite_id),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
        .sprite_scale(sprite_scale)
    );

    always #5 clk = ~clk;

    task automatic v(input logic rst, en, input logic [7:0] data, input logic deq, e,
                     input logic [7:0] id, input logic [15:0] x, y, input logic [7:0] sc);
        vecs.push_back('{rst, en, data, deq, e, id, x, y, sc});
    endtask

    task automatic step(input logic rst, en, input logic [7:0] data, input logic deq);
        reset = rst;
        enqueue_en = en;
        enqueue_data = data;
        dequeue = deq;
        @(posedge clk);
        #1;
        reset = 0;
        enqueue_en = 0;
        dequeue = 0;
    endtask

    task automatic check(input string name, input logic e, input logic [7:0] id,
                         input logic [15:0] x, y, input logic [7:0] sc);
        tests++;
        if (is_empty !== e || sprite_id !== id || sprite_x !== x || sprite_y !== y || sprite_scale !== sc) begin
            fails++;
            $display("FAIL %s: got empty=%b id=%h x=%h y=%h scale=%h, expected empty=%b id=%h x=%h y=%h scale=%h",
                     name, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, e, id, x, y, sc);
        end
    endtask

    task automatic send(input logic [7:0] id, input logic [15:0] x, y, input logic [7:0] sc, input logic deq_last);
        step(0, 1, id, 0);
        step(0, 1, x[7:0], 0);
        step(0, 1, x[15:8], 0);
        step(0, 1, y[7:0], 0);
        step(0, 1, y[15:8], 0);
        step(0, 1, sc, deq_last);
    endtask

    function automatic logic [15:0] rx(input logic [7:0] k);
        return {k, ~k};
    endfunction

    function automatic logic [15:0] ry(input logic [7:0] k);
        return {8'h5A, k};
    endfunction

    function automatic logic [7:0] rs(input logic [7:0] k);
        return k ^ 8'hC3;
    endfunction

    initial begin
        // reset and idle
        v(1, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        for (int i = 0; i < 3; i++) v(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        // first record
        v(0, 1, 8'h01, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h10, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h04, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h80, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h02, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        // second record back-to-back, head stays on the first
        v(0, 1, 8'h02, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        v(0, 1, 8'h04, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        v(0, 1, 8'h04, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        v(0, 1, 8'h90, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        v(0, 1, 8'h00, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        v(0, 1, 8'h05, 0, 0, 8'h01, 16'h0410, 16'h0080, 8'h02);
        // pops, then a pop while empty
        v(0, 0, 8'h00, 1, 0, 8'h02, 16'h0404, 16'h0090, 8'h05);
        v(0, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        // abort after three bytes, then a full record
        v(0, 1, 8'hAA, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'hBB, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'hCC, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h07, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h01, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h02, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h03, 0, 0, 8'h07, 16'h0001, 16'h0002, 8'h03);
        v(0, 0, 8'h00, 0, 0, 8'h07, 16'h0001, 16'h0002, 8'h03);
        v(0, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        // one entry stored, completion and pop on the same edge
        v(0, 1, 8'h11, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h22, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h33, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h44, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h55, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h66, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h21, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h01, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h02, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h03, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h04, 0, 0, 8'h11, 16'h3322, 16'h5544, 8'h66);
        v(0, 1, 8'h05, 1, 0, 8'h21, 16'h0201, 16'h0403, 8'h05);
        v(0, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        // empty queue, completion and pop on the same edge: push wins, pop ignored
        v(0, 1, 8'h31, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++) v(0, 1, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h09, 1, 0, 8'h31, 16'h0000, 16'h0000, 8'h09);
        v(0, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        // reset mid-record discards the partial bytes
        v(0, 1, 8'h41, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 1, 8'h42, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(1, 1, 8'h43, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++) v(0, 1, 8'h44 + 8'(i), 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        v(0, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 16'h0000, 8'h00);

        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].data, vecs[i].deq);
            check($sformatf("vec%0d", i), vecs[i].e, vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].sc);
        end

        // fill to DEPTH, overflow drop, full with simultaneous pop, drain; twice for pointer wrap
        for (int r = 0; r < 2; r++) begin
            automatic logic [7:0] b = 8'(r * 64);
            for (int i = 0; i < DEPTH; i++) send(b + 8'(i), rx(b + 8'(i)), ry(b + 8'(i)), rs(b + 8'(i)), 0);
            check($sformatf("r%0d_full_head", r), 0, b, rx(b), ry(b), rs(b));
            send(b + 8'd40, rx(b + 8'd40), ry(b + 8'd40), rs(b + 8'd40), 0);
            check($sformatf("r%0d_overflow_drop", r), 0, b, rx(b), ry(b), rs(b));
            send(b + 8'd50, rx(b + 8'd50), ry(b + 8'd50), rs(b + 8'd50), 1);
            check($sformatf("r%0d_full_push_pop", r), 0, b + 8'd1, rx(b + 8'd1), ry(b + 8'd1), rs(b + 8'd1));
            for (int i = 1; i < DEPTH; i++) begin
                check($sformatf("r%0d_drain%0d", r, i), 0, b + 8'(i), rx(b + 8'(i)), ry(b + 8'(i)), rs(b + 8'(i)));
                step(0, 0, 8'h00, 1);
            end
            check($sformatf("r%0d_drain_last", r), 0, b + 8'd50, rx(b + 8'd50), ry(b + 8'd50), rs(b + 8'd50));
            step(0, 0, 8'h00, 1);
            check($sformatf("r%0d_empty", r), 1, 8'h00, 16'h0000, 16'h0000, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
